set_fields_ctrl: RTL and testbench

Parametrised, fully synchronous field-editing controller for user-settable multi-field values (date DD/MM/YY, time HH/MM/SS, alarm). It debounces two push-buttons, steps through NUM_FIELDS fields, increments the selected field with per-field min/max wrap-around and hold-to-autorepeat, and commits or aborts the edit. It sits between the board KEY pins and the clock/calendar datapath, which loads `userVal` when `finish` pulses.

---
 rtl/set_fields_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_set_fields_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_fields_ctrl.sv
// set_fields_ctrl: push-button editor for a packed multi-field value
// (date, time, alarm). KEY[0] advances to the next field, KEY[1] increments
// the current field with min/max wrap and hold-to-autorepeat. A rising edge
// of `on` starts an edit, `on` low aborts it, and an advance past the last
// field commits the working value and pulses `finish`.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | not editing; stage = NUM_FIELDS, userVal shows committed/iniVal
// S_EDIT | editing field r_stage; userVal shows the working value
module set_fields_ctrl #(
    parameter int NUM_FIELDS      = 3,
    parameter int FIELD_W         = 7,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] MIN_VALS = {7'd1, 7'd1, 7'd0},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] MAX_VALS = {7'd31, 7'd12, 7'd99},
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    localparam int STG_W          = $clog2(NUM_FIELDS + 1),
    localparam int VAL_W          = NUM_FIELDS * FIELD_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       KEY,
    input  logic             on,
    input  logic [VAL_W-1:0] iniVal,
    output logic [VAL_W-1:0] userVal,
    output logic             finish,
    output logic             busy,
    output logic [STG_W-1:0] stage
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0]  HOLD_LD   = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0]  REP_LD    = RP_W'(REPEAT_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_IDLE  = STG_W'(NUM_FIELDS);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(NUM_FIELDS - 1);

    typedef enum logic {
        S_IDLE,
        S_EDIT
    } state_t;

    // key synchronisers, debounced levels and registered press pulses
    logic [1:0]      r_key_s1;
    logic [1:0]      r_key_s2;
    logic [1:0]      r_key_db;
    logic [1:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_fall;

    // `on` synchroniser plus one delay stage for rising-edge detection
    logic r_on_s1;
    logic r_on_s2;
    logic r_on_d;

    // edit state
    state_t           r_state;
    logic [STG_W-1:0] r_stage;
    logic             r_busy;
    logic             r_finish;
    logic             r_valid;
    logic [VAL_W-1:0] r_working;
    logic [VAL_W-1:0] r_committed;
    logic             r_rep_armed;
    logic [RP_W-1:0]  r_rep_cnt;

    logic [VAL_W-1:0] w_working_inc;
    logic             w_on_rise;
    logic             w_abort;
    logic             w_adv;
    logic             w_inc;

    // a press fires when the debounce counter is about to accept a low level
    always_comb begin
        w_fall = '0;
        for (int k = 0; k < 2; k++) begin
            w_fall[k] = (r_key_s2[k] != r_key_db[k]) && (r_db_cnt[k] == DB_LAST)
                        && !r_key_s2[k];
        end
    end

    // synchronise and debounce both keys; any bounce restarts the count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_key_s1 <= 2'b11;
            r_key_s2 <= 2'b11;
            r_key_db <= 2'b11;
            r_press  <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_key_s1 <= KEY;
            r_key_s2 <= r_key_s1;
            r_press  <= w_fall;
            for (int k = 0; k < 2; k++) begin
                if (r_key_s2[k] != r_key_db[k]) begin
                    if (r_db_cnt[k] == DB_LAST) begin
                        r_key_db[k] <= r_key_s2[k];
                        r_db_cnt[k] <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    // synchronise the edit-enable level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_on_s1 <= 1'b0;
            r_on_s2 <= 1'b0;
            r_on_d  <= 1'b0;
        end else begin
            r_on_s1 <= on;
            r_on_s2 <= r_on_s1;
            r_on_d  <= r_on_s2;
        end
    end

    // per-field increment; only the field under edit changes, out-of-range
    // values (e.g. from iniVal) snap to MIN
    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_fld
        localparam int LSB = (NUM_FIELDS - 1 - i) * FIELD_W;
        logic [FIELD_W-1:0] w_cur;
        logic [FIELD_W-1:0] w_min;
        logic [FIELD_W-1:0] w_max;
        assign w_cur = r_working[LSB +: FIELD_W];
        assign w_min = MIN_VALS[LSB +: FIELD_W];
        assign w_max = MAX_VALS[LSB +: FIELD_W];
        assign w_working_inc[LSB +: FIELD_W] =
            (r_stage != STG_W'(i)) ? w_cur :
            ((w_cur < w_min) || (w_cur >= w_max)) ? w_min : (w_cur + FIELD_W'(1));
    end

    assign w_on_rise = r_on_s2 && !r_on_d;
    assign w_abort   = !r_on_s2;
    assign w_adv     = r_press[0];
    assign w_inc     = r_press[1];

    // edit FSM: abort beats advance, advance beats any increment or repeat tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_stage     <= STG_IDLE;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_valid     <= 1'b0;
            r_working   <= '0;
            r_committed <= '0;
            r_rep_armed <= 1'b0;
            r_rep_cnt   <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rep_armed <= 1'b0;
                    r_rep_cnt   <= '0;
                    if (w_on_rise) begin
                        r_state   <= S_EDIT;
                        r_stage   <= '0;
                        r_busy    <= 1'b1;
                        r_working <= iniVal;
                    end
                end
                S_EDIT: begin
                    if (w_abort) begin
                        r_state     <= S_IDLE;
                        r_stage     <= STG_IDLE;
                        r_busy      <= 1'b0;
                        r_rep_armed <= 1'b0;
                        r_rep_cnt   <= '0;
                    end else if (w_adv) begin
                        r_rep_armed <= 1'b0;
                        r_rep_cnt   <= '0;
                        if (r_stage == STG_LAST) begin
                            r_committed <= r_working;
                            r_valid     <= 1'b1;
                            r_finish    <= 1'b1;
                            r_state     <= S_IDLE;
                            r_stage     <= STG_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_stage <= r_stage + STG_W'(1);
                        end
                    end else if (w_inc) begin
                        r_working   <= w_working_inc;
                        r_rep_armed <= 1'b1;
                        r_rep_cnt   <= HOLD_LD;
                    end else if (r_rep_armed) begin
                        if (r_key_db[1]) begin
                            r_rep_armed <= 1'b0;
                            r_rep_cnt   <= '0;
                        end else if (r_rep_cnt == '0) begin
                            r_working <= w_working_inc;
                            r_rep_cnt <= REP_LD;
                        end else begin
                            r_rep_cnt <= r_rep_cnt - RP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= STG_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign userVal = r_busy ? r_working : (r_valid ? r_committed : iniVal);
    assign finish  = r_finish;
    assign busy    = r_busy;
    assign stage   = r_stage;

endmodule

// File: tb/tb_set_fields_ctrl.sv
// Bench for set_fields_ctrl with short debounce/hold/repeat timings.
// A field-level model (arrays of integers) predicts userVal/stage/busy and
// the number of finish pulses; hand sequences cover latency corner cases.
module tb_set_fields_ctrl;

    localparam int NF   = 3;
    localparam int FW   = 7;
    localparam int VW   = NF * FW;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    KEY;
    logic          on;
    logic [VW-1:0] iniVal;
    logic [VW-1:0] userVal;
    logic          finish;
    logic          busy;
    logic [1:0]    stage;

    set_fields_ctrl #(
        .NUM_FIELDS(NF), .FIELD_W(FW),
        .MIN_VALS({7'd1, 7'd1, 7'd0}), .MAX_VALS({7'd31, 7'd12, 7'd99}),
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .CLK(CLK), .RST(RST), .KEY(KEY), .on(on), .iniVal(iniVal),
        .userVal(userVal), .finish(finish), .busy(busy), .stage(stage)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int fin_seen = 0;

    always @(negedge CLK) if (finish === 1'b1) fin_seen++;

    // reference model
    int MINV [NF] = '{1, 1, 0};
    int MAXV [NF] = '{31, 12, 99};
    int m_work [NF];
    int m_com  [NF];
    bit m_valid = 0;
    bit m_busy  = 0;
    int m_stage = NF;
    int m_fin   = 0;

    typedef struct {
        logic [VW-1:0] ini;
        int            n_adv;
        logic [VW-1:0] exp;
    } wrap_vec_t;
    wrap_vec_t tbl [7];

    function automatic logic [VW-1:0] pk(input int a, input int b, input int c);
        return {FW'(a), FW'(b), FW'(c)};
    endfunction

    function automatic logic [VW-1:0] m_expect();
        if (m_busy) return pk(m_work[0], m_work[1], m_work[2]);
        if (m_valid) return pk(m_com[0], m_com[1], m_com[2]);
        return iniVal;
    endfunction

    function automatic void m_inc();
        int f;
        if (!m_busy) return;
        f = m_work[m_stage];
        m_work[m_stage] = (f < MINV[m_stage] || f >= MAXV[m_stage]) ? MINV[m_stage] : f + 1;
    endfunction

    function automatic void m_adv();
        if (!m_busy) return;
        if (m_stage == NF - 1) begin
            for (int i = 0; i < NF; i++) m_com[i] = m_work[i];
            m_valid = 1;
            m_fin++;
            m_busy  = 0;
            m_stage = NF;
        end else begin
            m_stage++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_userVal"}, 32'(userVal), 32'(m_expect()));
        chk({tag, "_stage"}, 32'(stage), 32'(m_stage));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_finish_count"}, 32'(fin_seen), 32'(m_fin));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [VW-1:0] v);
        iniVal = v;
        if (on) begin
            on = 1'b0;
            repeat (3) tick();
        end
        on = 1'b1;
        repeat (2) tick();
        if (!m_busy) chk("start_latency_busy_low", 32'(busy), 32'd0);
        tick();
        if (!m_busy) begin
            m_busy  = 1;
            m_stage = 0;
            for (int i = 0; i < NF; i++) m_work[i] = int'(v[(NF-1-i)*FW +: FW]);
        end
    endtask

    task automatic do_abort();
        on = 1'b0;
        repeat (3) tick();
        m_busy  = 0;
        m_stage = NF;
    endtask

    // clean press of the masked keys, then a clean release
    task automatic do_press(input logic [1:0] mask);
        KEY = ~mask;
        repeat (DB + 3) tick();
        KEY = 2'b11;
        repeat (DB + 4) tick();
        if (mask[0]) m_adv();
        else if (mask[1]) m_inc();
    endtask

    // repeat ticks expected by relative cycle c with debounced release at rel
    function automatic int reps_by(input int c, input int rel);
        int lim;
        lim = (c < rel) ? c : rel;
        if (lim < HOLD) return 0;
        return 1 + (lim - HOLD) / REP;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reps;
        int fin_before;
        tbl[0] = '{pk(31, 6, 23),  0, pk(1, 6, 23)};
        tbl[1] = '{pk(15, 12, 23), 1, pk(15, 1, 23)};
        tbl[2] = '{pk(15, 6, 99),  2, pk(15, 6, 0)};
        tbl[3] = '{pk(40, 6, 23),  0, pk(1, 6, 23)};
        tbl[4] = '{pk(30, 0, 23),  1, pk(30, 1, 23)};
        tbl[5] = '{pk(5, 6, 127),  2, pk(5, 6, 0)};
        tbl[6] = '{pk(30, 6, 23),  0, pk(31, 6, 23)};

        // reset values
        RST = 1'b1; KEY = 2'b11; on = 1'b0; iniVal = pk(15, 6, 23);
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stage", 32'(stage), 32'd3);
        chk("reset_finish", 32'(finish), 32'd0);
        chk("reset_userVal", 32'(userVal), 32'(pk(15, 6, 23)));
        RST = 1'b0;
        repeat (2) tick();

        // abort before any commit: userVal falls back to iniVal
        do_start(pk(19, 6, 23));
        do_press(2'b10);
        chk("abort_edit_day20", 32'(userVal), 32'(pk(20, 6, 23)));
        do_abort();
        chk("abort_shows_ini", 32'(userVal), 32'(pk(19, 6, 23)));
        check_model("abort0");

        // full edit and commit, finish pulse timing
        do_start(pk(15, 6, 23));
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_stage", 32'(stage), 32'd0);
        chk("start_userVal", 32'(userVal), 32'(pk(15, 6, 23)));
        do_press(2'b01);
        do_press(2'b01);
        chk("stage2", 32'(stage), 32'd2);
        KEY = 2'b10;
        repeat (DB + 2) tick();
        chk("commit_early_finish", 32'(finish), 32'd0);
        chk("commit_early_busy", 32'(busy), 32'd1);
        tick();
        chk("commit_finish", 32'(finish), 32'd1);
        chk("commit_busy", 32'(busy), 32'd0);
        chk("commit_stage", 32'(stage), 32'd3);
        chk("commit_userVal", 32'(userVal), 32'(pk(15, 6, 23)));
        tick();
        chk("commit_finish_drop", 32'(finish), 32'd0);
        KEY = 2'b11;
        repeat (DB + 4) tick();
        m_adv();
        check_model("commit");
        iniVal = pk(1, 1, 1);
        tick();
        chk("committed_over_ini", 32'(userVal), 32'(pk(15, 6, 23)));

        // wrap table; every vector ends with an abort that keeps the commit
        for (int v = 0; v < 7; v++) begin
            do_start(tbl[v].ini);
            for (int a = 0; a < tbl[v].n_adv; a++) do_press(2'b01);
            do_press(2'b10);
            chk("wrap_value", 32'(userVal), 32'(tbl[v].exp));
            chk("wrap_stage", 32'(stage), 32'(tbl[v].n_adv));
            check_model("wrap");
            do_abort();
            chk("abort_keeps_commit", 32'(userVal), 32'(pk(15, 6, 23)));
        end

        // debounce: short glitch ignored, bouncy press counted once at latency
        do_start(pk(10, 6, 23));
        KEY = 2'b01;
        repeat (3) tick();
        KEY = 2'b11;
        repeat (12) tick();
        chk("glitch_ignored", 32'(userVal), 32'(pk(10, 6, 23)));
        KEY = 2'b01; tick();
        KEY = 2'b11; tick();
        KEY = 2'b01; repeat (2) tick();
        KEY = 2'b11; tick();
        KEY = 2'b01;
        repeat (DB + 2) tick();
        chk("bounce_before_latency", 32'(userVal), 32'(pk(10, 6, 23)));
        tick();
        chk("bounce_at_latency", 32'(userVal), 32'(pk(11, 6, 23)));
        repeat (10 - (DB + 3)) tick();
        KEY = 2'b11;
        repeat (DB + 4) tick();
        chk("bounce_single_inc", 32'(userVal), 32'(pk(11, 6, 23)));
        m_inc();
        check_model("bounce");

        // autorepeat: pin released after cycle 36, debounced release at 42
        KEY = 2'b01;
        repeat (DB + 3) tick();
        m_inc();
        check_model("rep_first");
        reps = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 37) KEY = 2'b11;
            tick();
            while (reps < reps_by(c, 36 + DB + 2)) begin
                m_inc();
                reps++;
            end
            check_model("rep");
        end
        chk("rep_total", 32'(userVal), 32'(pk(17, 6, 23)));

        // simultaneous advance + increment: advance wins
        do_press(2'b11);
        chk("simul_stage", 32'(stage), 32'd1);
        chk("simul_field0", 32'(userVal), 32'(pk(17, 6, 23)));
        check_model("simul");

        // randomized operations against the model
        for (int it = 0; it < 60; it++) begin
            if (!m_busy) begin
                do_start(pk($urandom_range(0, 127), $urandom_range(0, 127),
                            $urandom_range(0, 127)));
            end else begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) do_abort();
                else if (r <= 3) do_press(2'b01);
                else do_press(2'b10);
            end
            check_model("rnd");
        end

        // reset mid-edit with a press pending
        if (m_busy) do_abort();
        do_start(pk(3, 4, 5));
        do_press(2'b01);
        chk("pre_reset_stage", 32'(stage), 32'd1);
        fin_before = fin_seen;
        KEY = 2'b10;
        repeat (DB + 1) tick();
        RST = 1'b1;
        on  = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stage", 32'(stage), 32'd3);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_userVal", 32'(userVal), 32'(pk(3, 4, 5)));
        tick();
        RST = 1'b0;
        KEY = 2'b11;
        repeat (DB + 6) tick();
        chk("rst_no_finish", 32'(fin_seen), 32'(fin_before));
        chk("rst_stays_idle", 32'(busy), 32'd0);
        chk("rst_userVal_after", 32'(userVal), 32'(pk(3, 4, 5)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
